// File: rtl/ahfp_pkg.sv
// Shared constants, opcodes and FSM states for the ahfp_acc
// floating-point accumulator.
package ahfp_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;

    localparam int BIAS = 127;

    localparam logic [1:0] OP_ACC  = 2'd0;
    localparam logic [1:0] OP_CLR  = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_e;

    // Largest finite magnitude, sign bit excluded
    localparam logic [WORD_W-2:0] SAT_MAG = 31'h7F7F_FFFF;

endpackage

// File: rtl/ahfp_align.sv
// Truncating right shifter for mantissa alignment; shifts of
// MANT_W or more yield zero.
module ahfp_align
    import ahfp_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [EXP_W-1:0]  shamt_i,
    output logic [MANT_W-1:0] mant_o
);

    always_comb begin
        mant_o = '0;
        if (shamt_i < EXP_W'(MANT_W)) begin
            mant_o = mant_i >> shamt_i;
        end
    end

endmodule

// File: rtl/ahfp_acc.sv
// Multi-cycle single-precision accumulator, Nios II custom-instruction
// handshake. Define AHFP_ACC_SAT_EN to saturate on exponent overflow.
module ahfp_acc #(
    parameter int BIAS = ahfp_pkg::BIAS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
);

    import ahfp_pkg::*;

`ifdef AHFP_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [EXP_W-1:0] SAT_EXP = EXP_W'(2 * BIAS);
    localparam logic [WORD_W-2:0] SAT_L = {SAT_EXP, {FRAC_W{1'b1}}};

    state_e state_q, state_d;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] opd_q, opd_d;

    logic              sgn_q, sgn_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W:0]   mant_q, mant_d;
    logic              bsgn_q, bsgn_d;
    logic [MANT_W-1:0] bmant_q, bmant_d;
    logic              ovf_q, ovf_d;

    logic              a_zero, b_zero, a_big;
    logic [WORD_W-1:0] big_w, sml_w, oth_w;
    logic [EXP_W-1:0]  shamt;
    logic [MANT_W-1:0] sml_sh;
    logic [MANT_W:0]   sum;
    logic [WORD_W-1:0] fin;
    logic              finish;

    assign a_zero = (acc_q[30:23] == '0);
    assign b_zero = (opd_q[30:23] == '0);
    assign a_big  = (acc_q[30:23] >= opd_q[30:23]);
    assign big_w  = a_big ? acc_q : opd_q;
    assign sml_w  = a_big ? opd_q : acc_q;
    assign oth_w  = a_zero ? opd_q : acc_q;
    assign shamt  = big_w[30:23] - sml_w[30:23];
    assign sum    = mant_q + {1'b0, bmant_q};

    ahfp_align u_align (
        .mant_i  ({1'b1, sml_w[22:0]}),
        .shamt_i (shamt),
        .mant_o  (sml_sh)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        opd_d    = opd_q;
        sgn_d    = sgn_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        bsgn_d   = bsgn_q;
        bmant_d  = bmant_q;
        ovf_d    = ovf_q;
        fin      = '0;
        finish   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        (n == OP_ACC): begin
                            opd_d   = dataa;
                            state_d = S_ALIGN;
                        end
                        (n == OP_CLR): begin
                            acc_d    = '0;
                            result_d = '0;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                        default: begin
                            result_d = acc_q;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_ALIGN: begin
                ovf_d = 1'b0;
                if (a_zero || b_zero) begin
                    // Zero operand: pass the other value straight to NORM
                    sgn_d   = oth_w[31];
                    exp_d   = oth_w[30:23];
                    mant_d  = (oth_w[30:23] == '0) ? '0
                            : {2'b01, oth_w[22:0]};
                    state_d = S_NORM;
                end else begin
                    sgn_d   = big_w[31];
                    exp_d   = big_w[30:23];
                    mant_d  = {2'b01, big_w[22:0]};
                    bsgn_d  = sml_w[31];
                    bmant_d = sml_sh;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_NORM;
                if (sgn_q == bsgn_q) begin
                    mant_d = sum;
                    if (sum[MANT_W]) begin
                        mant_d = sum >> 1;
                        exp_d  = exp_q + 1'b1;
                        ovf_d  = (exp_q == 8'hFE);
                    end
                end else if (mant_q[23:0] >= bmant_q) begin
                    mant_d = {1'b0, mant_q[23:0] - bmant_q};
                end else begin
                    mant_d = {1'b0, bmant_q - mant_q[23:0]};
                    sgn_d  = bsgn_q;
                end
            end
            S_NORM: begin
                if (mant_q == '0) begin
                    finish = 1'b1;
                end else if (mant_q[23]) begin
                    finish = 1'b1;
                    fin    = (SAT_EN && ovf_q) ? {sgn_q, SAT_L}
                           : {sgn_q, exp_q, mant_q[22:0]};
                end else begin
                    mant_d = {mant_q[MANT_W-1:0], 1'b0};
                    exp_d  = exp_q - 1'b1;
                    // Exponent underflow flushes to +0
                    finish = (exp_q == 8'd1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            acc_d    = fin;
            result_d = fin;
            done_d   = 1'b1;
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            opd_q    <= '0;
            sgn_q    <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            bsgn_q   <= 1'b0;
            bmant_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            opd_q    <= opd_d;
            sgn_q    <= sgn_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            bsgn_q   <= bsgn_d;
            bmant_q  <= bmant_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ahfp_acc.sv
// Self-checking bench for ahfp_acc: directed cases, stalls, aborts
// and a randomized dot-product run against a field-level model.
module tb_ahfp_acc;

`ifdef AHFP_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    int total = 0;
    int bad = 0;

    ahfp_acc dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Value-level model: acc + x with truncation, returns latency too
    function automatic void model(input logic [31:0] a,
                                  input logic [31:0] x,
                                  output logic [31:0] r,
                                  output int lat);
        int ea, eb, eg, es, mg, ms, s, e, d, k;
        bit sgb, sss, sg, ovf, fl;
        ea = int'(a[30:23]);
        eb = int'(x[30:23]);
        if (ea == 0 || eb == 0) begin
            if (ea == 0) r = (eb == 0) ? 32'h0 : x;
            else r = a;
            lat = 3;
            return;
        end
        if (ea >= eb) begin
            eg = ea; es = eb; sgb = a[31]; sss = x[31];
            mg = (1 << 23) | int'(a[22:0]);
            ms = (1 << 23) | int'(x[22:0]);
        end else begin
            eg = eb; es = ea; sgb = x[31]; sss = a[31];
            mg = (1 << 23) | int'(x[22:0]);
            ms = (1 << 23) | int'(a[22:0]);
        end
        d = eg - es;
        ms = (d >= 24) ? 0 : (ms >> d);
        e = eg;
        ovf = 0;
        if (sgb == sss) begin
            s = mg + ms;
            sg = sgb;
            if (s >= (1 << 24)) begin
                s = s >> 1;
                e = e + 1;
                ovf = (e == 255);
            end
        end else if (mg >= ms) begin
            s = mg - ms; sg = sgb;
        end else begin
            s = ms - mg; sg = sss;
        end
        k = 0;
        fl = 0;
        while (s != 0 && s < (1 << 23)) begin
            s = s << 1;
            e = e - 1;
            k++;
            if (e == 0) begin
                s = 0;
                fl = 1;
            end
        end
        lat = fl ? 3 + k : 4 + k;
        if (s == 0) r = 32'h0;
        else if (ovf && SAT) r = {sg, 31'h7F7FFFFF};
        else r = {sg, e[7:0], s[22:0]};
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] d,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        start = 1'b1;
        n = op;
        dataa = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 2'($urandom);
        dataa = $urandom;
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int lat;
        reset = 1'b1;
        clk_en = 1'b1;
        start = 1'b0;
        n = 2'd0;
        dataa = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (result !== 32'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: result=%h done=%b want 0/0",
                     result, done);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(2'd2, 32'h0, r, lat);
        total++;
        if (r !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL reset_read: got %h lat %0d want 0 lat 1",
                     r, lat);
        end
    endtask

    task automatic test_directed();
        logic [31:0] r;
        int lat;
        run_op(2'd0, 32'h3F800000, r, lat);
        total++;
        if (r !== 32'h3F800000 || lat != 3) begin
            bad++;
            $display("FAIL acc_zero_skip: got %h lat %0d want 3f800000 lat 3",
                     r, lat);
        end
        run_op(2'd0, 32'h40000000, r, lat);
        total++;
        if (r !== 32'h40400000 || lat != 4) begin
            bad++;
            $display("FAIL acc_1p2: got %h lat %0d want 40400000 lat 4",
                     r, lat);
        end
        run_op(2'd3, 32'h0, r, lat);
        total++;
        if (r !== 32'h40400000 || lat != 1) begin
            bad++;
            $display("FAIL read_3: got %h lat %0d want 40400000 lat 1",
                     r, lat);
        end
        run_op(2'd1, 32'h0, r, lat);
        total++;
        if (r !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL clr: got %h lat %0d want 0 lat 1", r, lat);
        end
        run_op(2'd0, 32'h40400000, r, lat);
        run_op(2'd0, 32'hC0000000, r, lat);
        total++;
        if (r !== 32'h3F800000 || lat != 5) begin
            bad++;
            $display("FAIL sub_norm1: got %h lat %0d want 3f800000 lat 5",
                     r, lat);
        end
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h3F800000, r, lat);
        run_op(2'd0, 32'hBF800000, r, lat);
        total++;
        if (r !== 32'h0 || lat != 4) begin
            bad++;
            $display("FAIL cancel: got %h lat %0d want 0 lat 4", r, lat);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r, want;
        int lat;
        want = SAT ? 32'h7F7FFFFF : 32'h7FFFFFFF;
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h7F7FFFFF, r, lat);
        run_op(2'd0, 32'h7F7FFFFF, r, lat);
        total++;
        if (r !== want || lat != 4) begin
            bad++;
            $display("FAIL overflow: got %h lat %0d want %h lat 4",
                     r, lat, want);
        end
        run_op(2'd2, 32'h0, r, lat);
        total++;
        if (r !== want) begin
            bad++;
            $display("FAIL overflow_read: got %h want %h", r, want);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] r;
        int lat;
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h3F800000, r, lat);
        @(negedge clk);
        start = 1'b1;
        n = 2'd0;
        dataa = 32'h40000000;
        @(posedge clk);
        #1;
        n = 2'd1;
        dataa = 32'h0;
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        r = result;
        @(posedge clk);
        #1;
        total++;
        if (r !== 32'h40400000 || lat != 4) begin
            bad++;
            $display("FAIL ignore_start: got %h lat %0d want 40400000 lat 4",
                     r, lat);
        end
        run_op(2'd2, 32'h0, r, lat);
        total++;
        if (r !== 32'h40400000) begin
            bad++;
            $display("FAIL ignore_start_read: got %h want 40400000", r);
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        int lat;
        bit early;
        bit stalled;
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h40400000, r, lat);
        @(negedge clk);
        start = 1'b1;
        n = 2'd0;
        dataa = 32'hC0000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        early = 0;
        stalled = 0;
        while (!done && lat < 64) begin
            if (lat == 3 && !stalled) begin
                clk_en = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (done) early = 1;
                end
                clk_en = 1'b1;
                stalled = 1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        total++;
        if (result !== 32'h3F800000 || lat != 8 || early) begin
            bad++;
            $display("FAIL stall_norm: got %h lat %0d early %0d want 3f800000 lat 8",
                     result, lat, early);
        end
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || result !== 32'h3F800000) begin
            bad++;
            $display("FAIL stall_done_hold: done=%b result=%h want 1/3f800000",
                     done, result);
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL stall_done_drop: done=%b want 0", done);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int lat;
        int pulses;
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h3F800000, r, lat);
        @(negedge clk);
        start = 1'b1;
        n = 2'd0;
        dataa = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        total++;
        if (result !== 32'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset_state: result=%h done=%b want 0/0",
                     result, done);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort_no_done: pulses=%0d want 0", pulses);
        end
        run_op(2'd2, 32'h0, r, lat);
        total++;
        if (r !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL abort_read: got %h lat %0d want 0 lat 1",
                     r, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, x, acc_m, want;
        int lat, want_lat;
        run_op(2'd1, 32'h0, r, lat);
        acc_m = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                x = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
            end else if ($urandom_range(0, 9) == 0 && acc_m[30:23] != 0) begin
                x = acc_m ^ 32'h80000000;
            end else begin
                x = {$urandom_range(0, 1) == 1,
                     8'($urandom_range(120, 134)),
                     23'($urandom)};
            end
            model(acc_m, x, want, want_lat);
            run_op(2'd0, x, r, lat);
            total++;
            if (r !== want || lat != want_lat) begin
                bad++;
                $display("FAIL rand_acc[%0d]: x=%h got %h lat %0d want %h lat %0d",
                         i, x, r, lat, want, want_lat);
            end
            acc_m = want;
        end
        run_op(2'd2, 32'h0, r, lat);
        total++;
        if (r !== acc_m) begin
            bad++;
            $display("FAIL rand_read: got %h want %h", r, acc_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat;
        run_op(2'd1, 32'h0, r, lat);
        run_op(2'd0, 32'h40000000, r, lat);
        total++;
        if (done !== 1'b0 || result !== 32'h40000000) begin
            bad++;
            $display("FAIL b2b_pulse_hold: done=%b result=%h want 0/40000000",
                     done, result);
        end
        run_op(2'd0, 32'h40000000, r, lat);
        total++;
        if (r !== 32'h40800000 || lat != 4) begin
            bad++;
            $display("FAIL b2b_acc: got %h lat %0d want 40800000 lat 4",
                     r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_ignore_start();
        test_stall();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
